// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state, funct3 and error encodings for the load/store unit
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FAULT    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational sub-word load extract/extend and store merge
module lsu_align (
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);
  import lsu_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_W:    o_rdata = i_word;
      F3_BU:   o_rdata = {24'd0, w_byte};
      F3_HU:   o_rdata = {16'd0, w_half};
      default: o_rdata = '0;
    endcase

    // Stores keep the untouched lanes of the old word read back from memory
    o_merged = i_word;
    case (i_funct3)
      F3_B:    o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      F3_H:    begin
        if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
        else          o_merged[15:0]  = i_wdata[15:0];
      end
      F3_W:    o_merged = i_wdata;
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage with read-modify-write sub-word stores
// Optional LSU_TRACE_EN: simulation-only trace of memory writes and load responses.
module load_store_unit #(
  parameter logic [31:0] DMEM_SIZE   = 32'h0004_0000,
  parameter int          CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wr_dat,
  output logic        rd_en,
  output logic        wr_en,
  input  logic [31:0] m_rd_dat
);
  import lsu_pkg::*;

  lsu_state_t  r_state;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;

  logic        w_half;
  logic        w_word;
  logic        w_legal;
  logic [31:0] w_addr;
  logic [1:0]  w_err;
  logic [31:0] w_rdata;
  logic [31:0] w_merged;

  always_comb begin
    w_half = (req_funct3 == F3_H) || (req_funct3 == F3_HU);
    w_word = (req_funct3 == F3_W);
    if (req_is_store)
      w_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || w_word;
    else
      w_legal = (req_funct3 == F3_B) || (req_funct3 == F3_BU) || w_half || w_word;

    // Without alignment checking the sub-size address bits are simply dropped
    w_addr = req_addr;
    if (CHECK_ALIGN == 0) begin
      if (w_word)      w_addr[1:0] = 2'b00;
      else if (w_half) w_addr[0]   = 1'b0;
    end

    if (!w_legal)
      w_err = ERR_ILLEGAL;
    else if ((CHECK_ALIGN != 0) &&
             ((w_half && req_addr[0]) || (w_word && (req_addr[1:0] != 2'b00))))
      w_err = ERR_MISALIGN;
    else if (req_addr >= DMEM_SIZE)
      w_err = ERR_FAULT;
    else
      w_err = ERR_NONE;
  end

  lsu_align u_align (
    .i_word   (m_rd_dat),
    .i_wdata  (r_wdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_rdata  (w_rdata),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_funct3   <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_NONE;
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      m_addr     <= '0;
      m_wr_dat   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_is_store <= req_is_store;
            r_funct3   <= req_funct3;
            r_off      <= w_addr[1:0];
            r_wdata    <= req_wdata;
            req_ready  <= 1'b0;
            if (w_err != ERR_NONE) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= w_err;
            end else if (req_is_store && w_word) begin
              r_state  <= S_WR;
              wr_en    <= 1'b1;
              m_addr   <= {2'b00, w_addr[31:2]};
              m_wr_dat <= req_wdata;
            end else begin
              r_state <= S_RD;
              rd_en   <= 1'b1;
              m_addr  <= {2'b00, w_addr[31:2]};
            end
          end
        end
        S_RD: begin
          rd_en   <= 1'b0;
          r_state <= S_CAP;
        end
        S_CAP: begin
          if (r_is_store) begin
            r_state  <= S_WR;
            wr_en    <= 1'b1;
            m_wr_dat <= w_merged;
          end else begin
            r_state    <= S_RESP;
            m_addr     <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= w_rdata;
            resp_err   <= ERR_NONE;
          end
        end
        S_WR: begin
          r_state    <= S_RESP;
          wr_en      <= 1'b0;
          m_addr     <= '0;
          m_wr_dat   <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= ERR_NONE;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state    <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_TRACE_EN
  logic [31:0] r_trace_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_trace_addr <= '0;
    else if (req_valid && req_ready)
      r_trace_addr <= req_addr;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      $display("ST %08h %08h", {m_addr[29:0], 2'b00}, m_wr_dat);
    if (resp_valid && resp_ready && !r_is_store)
      $display("LD %08h %08h", r_trace_addr, resp_rdata);
  end
`else
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit against a transaction-level model
module tb_load_store_unit;

  localparam logic [31:0] DMEM = 32'h0004_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] m_addr, m_wr_dat, m_rd_dat;
  logic        rd_en, wr_en;

  logic [31:0] dmem [0:65535];
  logic        pre_en;
  logic [15:0] pre_idx;
  logic [31:0] pre_dat;

  logic [31:0] ref_mem [int unsigned];
  logic [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  int total = 0;
  int bad   = 0;

  int          e_lat, e_stall;
  bit          e_rd, e_wr;
  logic [1:0]  e_err;
  logic [31:0] e_idx, e_rdata, e_wdat;

  always #5 clk = ~clk;

  load_store_unit #(.DMEM_SIZE(DMEM), .CHECK_ALIGN(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .m_addr(m_addr), .m_wr_dat(m_wr_dat),
    .rd_en(rd_en), .wr_en(wr_en), .m_rd_dat(m_rd_dat)
  );

  // Word-wide data memory with one-cycle registered read
  always @(posedge clk) begin
    if (pre_en)     dmem[pre_idx] <= pre_dat;
    else if (wr_en) dmem[m_addr[15:0]] <= m_wr_dat;
    if (rd_en)      m_rd_dat <= dmem[m_addr[15:0]];
  end

  initial begin
    #800000;
    $display("FAIL timeout: simulation did not complete, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    pre_en = 1'b1; pre_idx = a[17:2]; pre_dat = w;
    ref_mem[a / 4] = w;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Transaction-level expectation from the access rules, using plain arithmetic
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    logic [31:0] old, v, mask;
    int          sz, sh;
    bit          legal;
    legal = st ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    sz = 1 << (f3 % 4);
    if (!legal)             e_err = 2'd3;
    else if (a % sz != 0)   e_err = 2'd1;
    else if (a >= DMEM)     e_err = 2'd2;
    else                    e_err = 2'd0;
    e_idx = a / 4;
    sh    = (a % 4) * 8;
    old   = ref_mem.exists(a / 4) ? ref_mem[a / 4] : 32'd0;
    e_rd  = (e_err == 0) && !(st && f3 == 3'd2);
    e_wr  = (e_err == 0) && st;
    e_lat = (e_err != 0) ? 1 : (st && f3 == 3'd2) ? 2 : st ? 4 : 3;
    e_rdata = 32'd0;
    e_wdat  = 32'd0;
    if (e_err == 0 && !st) begin
      v = old >> sh;
      if (sz == 1)      v = v & 32'hFF;
      else if (sz == 2) v = v & 32'hFFFF;
      if (f3 == 3'd0 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      e_rdata = v;
    end
    if (e_wr) begin
      mask   = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1) << sh;
      e_wdat = (old & ~mask) | ((wd << sh) & mask);
    end
  endtask

  task automatic compare_cycle(input int k);
    bit in_resp;
    if (k == 0) begin
      chk("accept req_ready", req_ready, 1);
      chk("accept rd_en", rd_en, 0);
      chk("accept wr_en", wr_en, 0);
      chk("accept resp_valid", resp_valid, 0);
    end else begin
      in_resp = (k >= e_lat) && (k <= e_lat + e_stall);
      chk($sformatf("rd_en c%0d", k), rd_en, e_rd && k == 1);
      chk($sformatf("wr_en c%0d", k), wr_en, e_wr && k == e_lat - 1);
      if (e_err == 0 && k < e_lat)
        chk($sformatf("m_addr c%0d", k), m_addr, e_idx);
      if (e_wr && k == e_lat - 1)
        chk($sformatf("m_wr_dat c%0d", k), m_wr_dat, e_wdat);
      chk($sformatf("resp_valid c%0d", k), resp_valid, in_resp);
      if (in_resp) begin
        chk($sformatf("resp_rdata c%0d", k), resp_rdata, e_rdata);
        chk($sformatf("resp_err c%0d", k), resp_err, e_err);
      end
      chk($sformatf("req_ready c%0d", k), req_ready, k == e_lat + e_stall + 1);
    end
  endtask

  // One request from acceptance to the first idle cycle; upstream keeps junk valid while busy
  task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int stall);
    model(st, f3, a, wd);
    e_stall = stall;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = 1'b0;
    for (int k = 0; k <= e_lat + stall + 1; k++) begin
      @(negedge clk);
      compare_cycle(k);
      @(posedge clk); #1;
      if (k + 1 <= e_lat + stall) begin
        req_valid    = 1'b1;
        req_is_store = 1'($urandom_range(0, 1));
        req_funct3   = 3'($urandom_range(0, 7));
        req_addr     = $urandom_range(0, 63);
        req_wdata    = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      resp_ready = (k + 1 >= e_lat + stall);
    end
    if (e_wr) ref_mem[a / 4] = e_wdat;
  endtask

  initial begin
    int wr_seen;
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    pre_en = 1'b0; pre_idx = '0; pre_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", req_ready, 1);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_rdata", resp_rdata, 0);
    chk("reset resp_err", resp_err, 0);
    chk("reset rd_en", rd_en, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset m_addr", m_addr, 0);
    chk("reset m_wr_dat", m_wr_dat, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    preload(32'h100, 32'h8899_AABC);
    run(1'b0, 3'd0, 32'h101, 32'd0, 0);
    chk("pin lb rdata", e_rdata, 32'hFFFF_FFAA);
    chk("pin lb index", e_idx, 32'h40);
    run(1'b0, 3'd1, 32'h100, 32'd0, 0);
    chk("pin lh rdata", e_rdata, 32'hFFFF_AABC);
    run(1'b0, 3'd4, 32'h103, 32'd0, 0);
    chk("pin lbu rdata", e_rdata, 32'h0000_0088);

    run(1'b1, 3'd2, 32'h200, 32'hDEAD_BEEF, 0);
    chk("pin sw wdat", e_wdat, 32'hDEAD_BEEF);
    run(1'b0, 3'd2, 32'h200, 32'd0, 0);
    chk("pin lw rdata", e_rdata, 32'hDEAD_BEEF);

    preload(32'h300, 32'h1122_3344);
    run(1'b1, 3'd1, 32'h302, 32'h0000_ABCD, 0);
    chk("pin sh wdat", e_wdat, 32'hABCD_3344);
    run(1'b0, 3'd5, 32'h302, 32'd0, 0);
    chk("pin lhu rdata", e_rdata, 32'h0000_ABCD);

    run(1'b0, 3'd2, 32'h102, 32'd0, 0);
    chk("pin misalign err", e_err, 2'd1);
    run(1'b0, 3'd2, DMEM, 32'd0, 0);
    chk("pin fault err", e_err, 2'd2);
    run(1'b0, 3'd3, 32'h100, 32'd0, 0);
    chk("pin illegal err", e_err, 2'd3);

    run(1'b0, 3'd0, 32'h102, 32'd0, 5);
    chk("pin stall rdata", e_rdata, 32'hFFFF_FF99);

    // Reset while an SB read-modify-write sits in CAP
    preload(32'h400, 32'h5566_7788);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h401; req_wdata = 32'h0000_00EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("sb rd_en in RD", rd_en, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid-reset req_ready", req_ready, 1);
    chk("mid-reset rd_en", rd_en, 0);
    chk("mid-reset wr_en", wr_en, 0);
    chk("mid-reset m_addr", m_addr, 0);
    chk("mid-reset m_wr_dat", m_wr_dat, 0);
    chk("mid-reset resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    wr_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (wr_en) wr_seen++;
    end
    @(posedge clk); #1;
    chk("no wr_en after reset", wr_seen, 0);
    chk("abandoned sb word", dmem[16'h100], 32'h5566_7788);
    run(1'b0, 3'd2, 32'h400, 32'd0, 0);
    chk("pin reload rdata", e_rdata, 32'h5566_7788);

    for (int i = 0; i < 16; i++) preload(i * 4, $urandom);
    for (int i = 0; i < 4; i++)  preload(32'h3FFF0 + i * 4, $urandom);

    for (int n = 0; n < 250; n++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a;
      int          r;
      st = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r == 0)  f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else         f3 = load_f3[$urandom_range(0, 4)];
      r = $urandom_range(0, 9);
      if (r < 7)       a = $urandom_range(0, 63);
      else if (r < 9)  a = 32'h3FFF0 + $urandom_range(0, 15);
      else             a = $urandom | DMEM;
      if ($urandom_range(0, 2) != 0) begin
        if (f3[1:0] == 2'd2)      a[1:0] = 2'b00;
        else if (f3[1:0] == 2'd1) a[0]   = 1'b0;
      end
      run(st, f3, a, $urandom, $urandom_range(0, 3));
    end

    foreach (ref_mem[i])
      chk($sformatf("mem word %0h", i), dmem[16'(i)], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
